issue_arb_rr: RTL

- Parametrised N-entry to M-port issue select for the out-of-order issue queue.
- Each cycle it compacts up to M requesting entries onto M issue ports in rotational priority order, starting from a round-robin pointer. RR_EN=0 gives the legacy fixed lowest-index-first order.
- Selected data is held in a registered output stage with a single valid/ready handshake toward the execute dispatch stage.
- Grants back to the queue fire only in the cycle the output stage loads.

---
 rtl/issue_arb_rr.sv | 125 ++++++++++++
 1 files changed

// File: rtl/issue_arb_rr.sv
// N-entry to M-port issue select with a rotating priority pointer and a
// registered, all-or-nothing valid/ready output stage toward dispatch.
module issue_arb_rr #(
  parameter int N     = 12,
  parameter int M     = 4,
  parameter int W     = 160,
  parameter int RR_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [N-1:0]         i_req,
  input  logic [N*W-1:0]       i_data,
  output logic [N-1:0]         i_grant,
  output logic [M-1:0]         o_valid,
  output logic [M*W-1:0]       o_data,
  input  logic                 o_ready,
  output logic [$clog2(N)-1:0] o_ptr
);

  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;

  logic [M-1:0]   valid_q, valid_d;
  logic [M*W-1:0] data_q, data_d;
  logic [PW-1:0]  ptr_q, ptr_d;

  logic           load;
  logic [N-1:0]   rotReq;
  logic [N-1:0]   selMask;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  idx;
  logic [PW-1:0]  selIdx [M];
  logic [PW-1:0]  lastIdx;

  assign load = ~flush & (~|valid_q | o_ready);

  // Rotate requests so bit j is entry (ptr+j) mod N, then walk the rotated
  // vector and hand the first M hits to ports 0..M-1 in that order.
  always_comb begin
    rotReq  = (i_req >> ptr_q) | (i_req << (CW'(N) - CW'(ptr_q)));
    cnt     = '0;
    idx     = '0;
    selMask = '0;
    for (int k = 0; k < M; k++) begin
      selIdx[k] = '0;
    end
    for (int j = 0; j < N; j++) begin
      if (rotReq[j] && (cnt < CW'(M))) begin
        idx = CW'(ptr_q) + CW'(j);
        if (idx >= CW'(N)) begin
          idx = idx - CW'(N);
        end
        for (int k = 0; k < M; k++) begin
          if (cnt == CW'(k)) begin
            selIdx[k] = idx[PW-1:0];
          end
        end
        for (int i = 0; i < N; i++) begin
          if (idx == CW'(i)) begin
            selMask[i] = 1'b1;
          end
        end
        cnt = cnt + CW'(1);
      end
    end
  end

  // Grants are only visible when the output stage actually loads, and never
  // while reset is held so the queue cannot retire entries that get dropped.
  assign i_grant = (load && rst_n) ? selMask : '0;

  always_comb begin
    lastIdx = '0;
    for (int k = 0; k < M; k++) begin
      if (CW'(k) + CW'(1) == cnt) begin
        lastIdx = selIdx[k];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = '0;
      data_d  = '0;
      ptr_d   = '0;
    end else if (load) begin
      for (int k = 0; k < M; k++) begin
        if (CW'(k) < cnt) begin
          valid_d[k]       = 1'b1;
          data_d[k*W +: W] = i_data[int'(selIdx[k])*W +: W];
        end else begin
          valid_d[k]       = 1'b0;
          data_d[k*W +: W] = '0;
        end
      end
      if (cnt != '0) begin
        ptr_d = (lastIdx == PW'(N - 1)) ? '0 : lastIdx + PW'(1);
      end
    end
    if (RR_EN == 0) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ptr   = ptr_q;

endmodule
